// File: rtl/avmm_initiator_ctrl.sv
// Single-outstanding bridge from a valid/ready command port to pulse-style AVMM, with completion timeout.
// Latency: accept at N, strobe at N+2, response valid one cycle after the completion (N+4 for a 1-cycle target).
// Backpressure: cmd_ready only in IDLE; waitrq delays the strobe (bounded by timeout); response held until rsp_ready.
module avmm_initiator_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_byteen,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_status,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          avmm_addr,
    output logic                 avmm_read,
    output logic                 avmm_write,
    output logic [31:0]          avmm_wdata,
    output logic [3:0]           avmm_byteen,
    input  logic                 avmm_waitrq,
    input  logic                 avmm_rdvalid,
    input  logic                 avmm_wrvalid,
    input  logic [1:0]           avmm_response,
    input  logic [31:0]          avmm_rdata
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BUSY = 3'd1,
        S_CMD       = 3'd2,
        S_WAIT_RSP  = 3'd3,
        S_RSP       = 3'd4
    } state_t;

    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_TERR  = 2'b01;
    localparam logic [1:0]  ST_TMO   = 2'b10;
    // Counter value on the last cycle allowed in a waiting state.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_tmo_cnt,     w_tmo_cnt_nxt;
    logic                  r_is_write,    w_is_write_nxt;
    logic                  r_cmd_ready,   w_cmd_ready_nxt;
    logic                  r_rsp_valid,   w_rsp_valid_nxt;
    logic [31:0]           r_rsp_rdata,   w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_status,  w_rsp_status_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt,     w_err_cnt_nxt;
    logic [31:0]           r_avmm_addr,   w_avmm_addr_nxt;
    logic                  r_avmm_read,   w_avmm_read_nxt;
    logic                  r_avmm_write,  w_avmm_write_nxt;
    logic [31:0]           r_avmm_wdata,  w_avmm_wdata_nxt;
    logic [3:0]            r_avmm_byteen, w_avmm_byteen_nxt;

    logic w_done;
    logic w_tmo_hit;

    // Only a completion of the latched direction counts, and only while waiting for it.
    assign w_done    = (r_state == S_WAIT_RSP) && (r_is_write ? avmm_wrvalid : avmm_rdvalid);
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a completion has priority over the timeout on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (cmd_valid) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!avmm_waitrq)   w_state_nxt = S_CMD;
                else if (w_tmo_hit) w_state_nxt = S_RSP;
            end
            S_CMD:       w_state_nxt = S_WAIT_RSP;
            S_WAIT_RSP:  begin
                if (w_done)         w_state_nxt = S_RSP;
                else if (w_tmo_hit) w_state_nxt = S_RSP;
            end
            S_RSP:       if (rsp_ready) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of every registered output; the strobe defaults low so it lasts one cycle.
    always_comb begin
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_is_write_nxt    = r_is_write;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_status_nxt  = r_rsp_status;
        w_avmm_addr_nxt   = r_avmm_addr;
        w_avmm_wdata_nxt  = r_avmm_wdata;
        w_avmm_byteen_nxt = r_avmm_byteen;
        w_avmm_read_nxt   = 1'b0;
        w_avmm_write_nxt  = 1'b0;
        w_cmd_ready_nxt   = (w_state_nxt == S_IDLE);
        w_err_cnt_nxt     = r_err_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_avmm_addr_nxt   = cmd_addr;
                    w_avmm_wdata_nxt  = cmd_wdata;
                    w_avmm_byteen_nxt = cmd_byteen;
                    w_is_write_nxt    = cmd_write;
                    w_tmo_cnt_nxt     = 16'd0;
                end
            end
            S_WAIT_BUSY: begin
                if (!avmm_waitrq) begin
                    w_avmm_read_nxt  = !r_is_write;
                    w_avmm_write_nxt = r_is_write;
                end else if (w_tmo_hit) begin
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_rdata_nxt  = 32'd0;
                    w_rsp_status_nxt = ST_TMO;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
            end
            S_CMD: begin
                // Targets raise waitrq off the strobe itself, so it is not looked at here.
                w_tmo_cnt_nxt = 16'd0;
            end
            S_WAIT_RSP: begin
                if (w_done) begin
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_rdata_nxt  = r_is_write ? 32'd0 : avmm_rdata;
                    w_rsp_status_nxt = (avmm_response != 2'b00) ? ST_TERR : ST_OK;
                end else if (w_tmo_hit) begin
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_rdata_nxt  = 32'd0;
                    w_rsp_status_nxt = ST_TMO;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
            end
            S_RSP: begin
                if (rsp_ready) w_rsp_valid_nxt = 1'b0;
            end
            default: ;
        endcase

        // Count each non-OK response once, on entry to RSP, saturating at all-ones.
        if ((r_state != S_RSP) && (w_state_nxt == S_RSP) &&
            (w_rsp_status_nxt != ST_OK) && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt     <= 16'd0;
            r_is_write    <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_status  <= ST_OK;
            r_err_cnt     <= '0;
            r_avmm_addr   <= 32'd0;
            r_avmm_read   <= 1'b0;
            r_avmm_write  <= 1'b0;
            r_avmm_wdata  <= 32'd0;
            r_avmm_byteen <= 4'd0;
        end else begin
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_is_write    <= w_is_write_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_status  <= w_rsp_status_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
            r_avmm_addr   <= w_avmm_addr_nxt;
            r_avmm_read   <= w_avmm_read_nxt;
            r_avmm_write  <= w_avmm_write_nxt;
            r_avmm_wdata  <= w_avmm_wdata_nxt;
            r_avmm_byteen <= w_avmm_byteen_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_status  = r_rsp_status;
    assign err_cnt     = r_err_cnt;
    assign avmm_addr   = r_avmm_addr;
    assign avmm_read   = r_avmm_read;
    assign avmm_write  = r_avmm_write;
    assign avmm_wdata  = r_avmm_wdata;
    assign avmm_byteen = r_avmm_byteen;

endmodule
